// File: rtl/sram_controller.sv
// MEM-stage backend: turns single-cycle 32-bit word requests into two-halfword
// accesses on a 16-bit asynchronous SRAM, holding ready low until the access is done.
module sram_controller #(
  parameter int ACCESS_CYCLES = 5,
  parameter int MEM_BASE      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [16:0] wa_reg;
  logic [31:0] data_reg;
  logic        wr_reg;
  logic [31:0] read_data_reg;
  logic [17:0] sram_addr_reg;
  logic        we_n_reg;
  logic        dq_oe_reg;
  logic [15:0] dq_out_reg;

  logic        req;
  logic [31:0] offset;
  logic [16:0] wa_next;
  logic        unused_offset_bits;

  assign req     = rd_en | wr_en;
  // The subtraction wraps silently for addresses below MEM_BASE.
  assign offset  = address - 32'(MEM_BASE);
  assign wa_next = offset[18:2];
  assign unused_offset_bits = &{1'b0, offset[31:19], offset[1:0]};

  // Bus outputs are registered: each transition loads the values for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      wa_reg        <= 17'd0;
      data_reg      <= 32'd0;
      wr_reg        <= 1'b0;
      read_data_reg <= 32'd0;
      sram_addr_reg <= 18'd0;
      we_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      dq_out_reg    <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            wa_reg        <= wa_next;
            data_reg      <= write_data;
            wr_reg        <= wr_en;
            cnt_reg       <= 4'd1;
            state_reg     <= LOW;
            sram_addr_reg <= {wa_next, 1'b0};
            we_n_reg      <= ~wr_en;
            dq_oe_reg     <= wr_en;
            dq_out_reg    <= write_data[15:0];
          end
        end
        LOW: begin
          if (!wr_reg) read_data_reg[15:0] <= SRAM_DQ;
          cnt_reg       <= cnt_reg + 4'd1;
          state_reg     <= HIGH;
          sram_addr_reg <= {wa_reg, 1'b1};
          dq_out_reg    <= data_reg[31:16];
        end
        HIGH: begin
          if (!wr_reg) read_data_reg[31:16] <= SRAM_DQ;
          cnt_reg       <= cnt_reg + 4'd1;
          state_reg     <= (ACCESS_CYCLES == 3) ? DONE : WAIT;
          sram_addr_reg <= {wa_reg, 1'b0};
          we_n_reg      <= 1'b1;
          dq_oe_reg     <= 1'b0;
        end
        WAIT: begin
          // cnt_reg tracks the cycle index since the request was detected.
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == 4'(ACCESS_CYCLES - 1)) state_reg <= DONE;
        end
        DONE: begin
          cnt_reg       <= 4'd0;
          state_reg     <= IDLE;
          sram_addr_reg <= 18'd0;
        end
        default: begin
          state_reg     <= IDLE;
          sram_addr_reg <= 18'd0;
          we_n_reg      <= 1'b1;
          dq_oe_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ~req | (state_reg == DONE);
  assign read_data = read_data_reg;
  assign SRAM_ADDR = sram_addr_reg;
  assign SRAM_WE_N = we_n_reg;
  assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'bz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: vector table of word accesses against a
// behavioural async SRAM, plus hand sequences for req drop and mid-access reset.
module tb_sram_controller;
  localparam int AC = 5;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:255];

  sram_controller #(.ACCESS_CYCLES(AC), .MEM_BASE(1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: combinational read while WE_N is high.
  assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : 16'bz;
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] sa;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending DONE.
  task automatic run_access(input int idx, input vec_t v);
    logic [7:0] mi;
    mi         = v.sa[7:0];
    rd_en      = v.rd;
    wr_en      = v.wr;
    address    = v.addr;
    write_data = v.wdata;
    for (int c = 0; c <= AC; c++) begin
      @(negedge clk);
      check($sformatf("v%0d ready c%0d", idx, c), {31'd0, ready}, {31'd0, c == AC});
      if (c == 1) begin
        check($sformatf("v%0d addr lo", idx), {14'd0, sram_addr}, {14'd0, v.sa});
        check($sformatf("v%0d we_n lo", idx), {31'd0, sram_we_n}, {31'd0, !v.wr});
        if (v.wr) check($sformatf("v%0d dq lo", idx), {16'd0, sram_dq}, {16'd0, v.wdata[15:0]});
      end
      if (c == 2) begin
        check($sformatf("v%0d addr hi", idx), {14'd0, sram_addr}, {14'd0, v.sa} + 32'd1);
        if (v.wr) check($sformatf("v%0d dq hi", idx), {16'd0, sram_dq}, {16'd0, v.wdata[31:16]});
      end
      if (c == 3) check($sformatf("v%0d rdata c3", idx), read_data, v.exp_rd);
      @(posedge clk);
      #1;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    check($sformatf("v%0d rdata end", idx), read_data, v.exp_rd);
    if (v.wr) begin
      check($sformatf("v%0d mem lo", idx), {16'd0, mem[mi]}, {16'd0, v.wdata[15:0]});
      check($sformatf("v%0d mem hi", idx), {16'd0, mem[mi + 8'd1]}, {16'd0, v.wdata[31:16]});
    end
    $display("[TB] access %0d rd=%0b wr=%0b addr=%0d wdata=%h read_data=%h", idx, v.rd, v.wr,
             v.addr, v.wdata, read_data);
  endtask

  initial begin
    vec_t extra;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2,      32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2,      32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 18'd0,      32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 18'd0,      32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4,      32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 18'd4,      32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 18'h3FFFE,  32'hCAFEF00D};
    vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 18'h3FFFE,  32'h0BADC0DE};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset we_n", {31'd0, sram_we_n}, 32'd1);
    check("reset rdata", read_data, 32'd0);
    check("reset addr", {14'd0, sram_addr}, 32'd0);
    check("reset ties", {28'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 32'd0);
    $display("[TB] reset done");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Consecutive entries run back to back: each starts in the IDLE cycle after DONE.
    for (int i = 0; i < 8; i++) run_access(i, vecs[i]);

    // Request dropped mid-access: the access still completes, ready follows ~req.
    rd_en = 1'b1; address = 32'd1024;
    @(negedge clk);
    check("drop ready c0", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    check("drop ready c1", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop addr c2", {14'd0, sram_addr}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("drop rdata", read_data, 32'h12345678);
    $display("[TB] dropped-request read read_data=%h", read_data);

    // Reset during the HIGH cycle of a write aborts the access.
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h55AA33CC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort addr hi", {14'd0, sram_addr}, 32'd7);
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort rdata", read_data, 32'd0);
    check("abort addr", {14'd0, sram_addr}, 32'd0);
    check("abort ready", {31'd0, ready}, 32'd1);
    $display("[TB] reset mid-access applied");
    @(posedge clk); #1;
    extra = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2, 32'hDEADBEEF};
    run_access(8, extra);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
